// File: rtl/timer_arb_pkg.sv
// rtl/timer_arb_pkg.sv - shared state encodings and constants for the Timer Wishbone arbiter
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          GAP_CNT_W    = 4;

endpackage

// File: rtl/timer_arb_rr_pick.sv
// rtl/timer_arb_rr_pick.sv - two-way round-robin pick, combinational
module timer_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // a lone requester always wins; on a tie the master not served last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/timer_wb_arbiter.sv
// rtl/timer_wb_arbiter.sv - 2-master Wishbone arbiter for the Timer peripheral; TIMER_ARB_TIMEOUT_EN adds a BUSY watchdog
module timer_wb_arbiter #(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  import timer_arb_pkg::*;

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYC - 1);

  arb_state_t           state;
  arb_state_t           state_n;
  logic [1:0]           req;
  logic [1:0]           pick;
  logic [1:0]           owner;
  logic                 last;
  logic                 owner_cyc;
  logic                 take;
  logic                 ack_fire;
  logic                 to_fire;
  logic                 to_hit;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic [31:0]          rdata;

  assign req       = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign owner_cyc = owner[1] ? m1_cyc_i : m0_cyc_i;

  timer_arb_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .grant (pick)
  );

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ARB_IDLE;
    else          state <= state_n;
  end

  // next state: grant from IDLE or end of GAP, finish on ack/abort/watchdog
  always_comb begin
    state_n  = state;
    take     = 1'b0;
    ack_fire = 1'b0;
    to_fire  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|req) begin
          state_n = ARB_BUSY;
          take    = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (!owner_cyc) begin
          state_n = ARB_GAP;
        end else if (s_ack_i) begin
          ack_fire = 1'b1;
          state_n  = ARB_GAP;
        end else if (to_hit) begin
          ack_fire = 1'b1;
          to_fire  = 1'b1;
          state_n  = ARB_GAP;
        end
      end
      ARB_GAP: begin
        if (gap_cnt == '0) begin
          if (|req) begin
            state_n = ARB_BUSY;
            take    = 1'b1;
          end else begin
            state_n = ARB_IDLE;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // latch the winner and its request at grant; held steady for the whole transfer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      owner    <= 2'b00;
      last     <= 1'b1;
      s_we_o   <= 1'b0;
      s_addr_o <= '0;
      s_sel_o  <= '0;
      s_data_o <= '0;
    end else if (take) begin
      owner <= pick;
      last  <= pick[1];
      if (pick[1]) begin
        s_we_o   <= m1_we_i;
        s_addr_o <= m1_addr_i;
        s_sel_o  <= m1_sel_i;
        s_data_o <= m1_data_i;
      end else begin
        s_we_o   <= m0_we_i;
        s_addr_o <= m0_addr_i;
        s_sel_o  <= m0_sel_i;
        s_data_o <= m0_data_i;
      end
    end
  end

  // idle gap counter: loaded on leaving BUSY, GAP ends when it reaches zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                  gap_cnt <= '0;
    else if (state == ARB_BUSY && state_n == ARB_GAP) gap_cnt <= GAP_LOAD;
    else if (state == ARB_GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
  end

`ifdef TIMER_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_flag;

  // count BUSY cycles of the current transfer; cleared in any other state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               to_cnt <= '0;
    else if (state == ARB_BUSY) to_cnt <= to_cnt + 1'b1;
    else                        to_cnt <= '0;
  end

  assign to_hit = (state == ARB_BUSY) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // sticky watchdog flag, only reset clears it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     to_flag <= 1'b0;
    else if (to_fire) to_flag <= 1'b1;
  end

  assign timeout_o = to_flag;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign to_hit         = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  assign s_cyc_o = (state == ARB_BUSY);
  assign s_stb_o = (state == ARB_BUSY);
  assign grant_o = (state == ARB_BUSY) ? owner : 2'b00;

  assign rdata     = to_fire ? TIMEOUT_DATA : s_data_i;
  assign m0_ack_o  = ack_fire & owner[0];
  assign m1_ack_o  = ack_fire & owner[1];
  assign m0_data_o = (state == ARB_BUSY && owner[0]) ? rdata : '0;
  assign m1_data_o = (state == ARB_BUSY && owner[1]) ? rdata : '0;

endmodule

// File: tb/tb_timer_wb_arbiter.sv
// tb/tb_timer_wb_arbiter.sv - self-checking bench for timer_wb_arbiter with a Timer slave model
module tb_timer_wb_arbiter;

  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;
`ifdef TIMER_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_data = 0, m1_addr = 0, m1_data = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_rd, m1_rd, s_addr_o, s_data_o;
  logic        m0_ack, m1_ack, s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;
  logic [31:0] s_data_i = 0;
  logic        s_ack_i = 0;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  timer_wb_arbiter #(.GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_sel_i(m0_sel), .m0_data_i(m0_data), .m0_data_o(m0_rd), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_sel_i(m1_sel), .m1_data_i(m1_data), .m1_data_o(m1_rd), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_sel_o(s_sel_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endfunction

  // Timer slave: acks two cycles after a cyc&stb rising edge, register file by addr[5:2]
  logic [31:0] treg [16];
  bit          stuck = 0;
  bit          force_ack = 0;
  int          age = -1;
  bit          prev_req = 0;
  initial foreach (treg[i]) treg[i] = 32'h0;

  always @(posedge clk) begin
    #2;
    s_ack_i  = 1'b0;
    s_data_i = 32'h0;
    if (!rst_n) begin
      age = -1;
      prev_req = 0;
    end else begin
      if (s_cyc_o && s_stb_o && !prev_req) age = 0;
      else if (s_cyc_o && s_stb_o && age >= 0) age++;
      else age = -1;
      prev_req = s_cyc_o && s_stb_o;
      if (age == 2 && !stuck) begin
        s_ack_i = 1'b1;
        if (s_we_o) begin
          for (int b = 0; b < 4; b++)
            if (s_sel_o[b]) treg[s_addr_o[5:2]][8*b +: 8] = s_data_o[8*b +: 8];
        end else begin
          s_data_i = treg[s_addr_o[5:2]];
        end
      end
      if (force_ack) s_ack_i = 1'b1;
    end
  end

  // reference model: transfer-level view (phase, owner, latched request, gap countdown)
  int          md_phase;
  int          md_owner, md_last, md_gap_left, md_busy_n;
  bit          md_to;
  logic        md_we;
  logic [31:0] md_addr, md_data;
  logic [3:0]  md_sel;

  task automatic model_reset();
    md_phase = 0; md_owner = 0; md_last = 1; md_gap_left = 0; md_busy_n = 0; md_to = 0;
    md_we = 0; md_addr = 0; md_sel = 0; md_data = 0;
  endtask

  task automatic model_grant(input logic [1:0] rq);
    int w;
    if (rq == 2'b11) w = 1 - md_last;
    else             w = rq[1] ? 1 : 0;
    md_owner = w; md_last = w; md_phase = 1; md_busy_n = 0;
    md_we   = w ? m1_we   : m0_we;
    md_addr = w ? m1_addr : m0_addr;
    md_sel  = w ? m1_sel  : m0_sel;
    md_data = w ? m1_data : m0_data;
  endtask

  int          ack_cnt0 = 0, ack_cnt1 = 0;
  int          stb_rise_cyc = -1;
  logic [1:0]  prev_grant = 0;
  bit          prev_stb = 0;
  int          grant_log [$];
  int          grant_cyc [$];

  logic [1:0]  c_rq;
  bit          c_busy, c_done, c_to;
  logic        c_a0, c_a1;
  logic [31:0] c_d0, c_d1, c_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_bus", {28'h0, s_cyc_o, s_stb_o, s_we_o, timeout_o}, 32'h0);
      chk("rst_addr", s_addr_o, 32'h0);
      chk("rst_wdata", s_data_o, 32'h0);
      chk("rst_grant_ack", {26'h0, s_sel_o, grant_o} | {30'h0, m0_ack, m1_ack}, 32'h0);
      chk("rst_rdata", m0_rd | m1_rd, 32'h0);
    end else begin
      c_rq   = {m1_cyc & m1_stb, m0_cyc & m0_stb};
      c_busy = (md_phase == 1);
      if (c_busy) md_busy_n++;
      c_done = 0; c_to = 0; c_a0 = 0; c_a1 = 0; c_d0 = 0; c_d1 = 0;
      if (c_busy) begin
        c_rd = s_data_i;
        if (!(md_owner ? m1_cyc : m0_cyc)) c_done = 1;
        else if (s_ack_i) c_done = 1;
        else if (TO_EN && md_busy_n == TIMEOUT_CYC) begin
          c_done = 1; c_to = 1; c_rd = 32'hDEAD_BEEF;
        end
        if (md_owner == 0) c_d0 = c_rd; else c_d1 = c_rd;
        if (c_done && (md_owner ? m1_cyc : m0_cyc)) begin
          if (md_owner == 0) c_a0 = 1; else c_a1 = 1;
        end
      end
      chk("s_cyc", 32'(s_cyc_o), 32'(c_busy));
      chk("s_stb", 32'(s_stb_o), 32'(c_busy));
      chk("s_we", 32'(s_we_o), 32'(md_we));
      chk("s_addr", s_addr_o, md_addr);
      chk("s_sel", 32'(s_sel_o), 32'(md_sel));
      chk("s_wdata", s_data_o, md_data);
      chk("grant", 32'(grant_o), c_busy ? (32'd1 << md_owner) : 32'd0);
      chk("m0_ack", 32'(m0_ack), 32'(c_a0));
      chk("m1_ack", 32'(m1_ack), 32'(c_a1));
      chk("m0_rdata", m0_rd, c_d0);
      chk("m1_rdata", m1_rd, c_d1);
      chk("timeout", 32'(timeout_o), 32'(md_to));
      if (c_done) begin
        md_phase = 2; md_gap_left = GAP_CYC;
        if (c_to) md_to = 1;
      end else if (md_phase == 0) begin
        if (c_rq != 0) model_grant(c_rq);
      end else if (md_phase == 2) begin
        md_gap_left--;
        if (md_gap_left == 0) begin
          if (c_rq != 0) model_grant(c_rq);
          else md_phase = 0;
        end
      end
    end
    if (m0_ack) ack_cnt0++;
    if (m1_ack) ack_cnt1++;
    if (s_stb_o && !prev_stb) stb_rise_cyc = cycle;
    prev_stb = s_stb_o;
    if (grant_o != 0 && prev_grant == 0) begin
      grant_log.push_back(int'(grant_o));
      grant_cyc.push_back(cycle);
    end
    prev_grant = grant_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input logic on, input logic we, input logic [31:0] addr, input logic [31:0] data);
    if (x == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = we; m0_addr = addr; m0_sel = 4'hF; m0_data = data;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = we; m1_addr = addr; m1_sel = 4'hF; m1_data = data;
    end
  endtask

  function automatic logic get_ack(input int x);
    return (x == 0) ? m0_ack : m1_ack;
  endfunction

  function automatic logic [31:0] get_rd(input int x);
    return (x == 0) ? m0_rd : m1_rd;
  endfunction

  // one master transfer; the address is disturbed mid-wait to show the latch holds
  task automatic xfer(input int x, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int req_at, output int ack_at);
    drive(x, 1'b1, we, addr, wdata);
    req_at = cycle;
    ack_at = -1;
    rdata  = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (i == 1) begin
        tick();
        if (x == 0) m0_addr = m0_addr ^ 32'h5A00_0000;
        else        m1_addr = m1_addr ^ 32'h5A00_0000;
      end
      @(negedge clk);
      if (get_ack(x)) begin
        ack_at = cycle;
        rdata  = get_rd(x);
        break;
      end
    end
    if (ack_at < 0) chk("xfer_wait", 32'd0, 32'd1);
    tick();
    drive(x, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    force_ack = 0;
    stuck = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  function automatic int grant_seq();
    int s = 0;
    foreach (grant_log[i]) s = (s << 4) | grant_log[i];
    return s;
  endfunction

  logic [31:0] rd_a, rd_b, rd_c;
  int          rq_a, rq_b, rq_c, ak_a, ak_b, ak_c;

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    repeat (2) tick();
    chk("reset_grant", 32'(grant_o), 32'h0);
    chk("reset_scyc", 32'(s_cyc_o), 32'h0);
    chk("reset_timeout", 32'(timeout_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: single write then readback
    xfer(0, 1'b1, 32'h10, 32'h0000_0400, rd_a, rq_a, ak_a);
    chk("t1_stb_latency", 32'(stb_rise_cyc - rq_a), 32'd1);
    chk("t1_ack_latency", 32'(ak_a - rq_a), 32'd3);
    xfer(0, 1'b0, 32'h10, 32'h0, rd_a, rq_a, ak_a);
    chk("t1_readback", rd_a, 32'h0000_0400);

    // 2: simultaneous requests after reset
    reset_dut();
    grant_log.delete(); grant_cyc.delete();
    fork
      xfer(0, 1'b1, 32'h14, 32'h0000_1111, rd_a, rq_a, ak_a);
      xfer(1, 1'b1, 32'h18, 32'h0000_2222, rd_b, rq_b, ak_b);
    join
    repeat (3) tick();
    chk("t2_grant_seq", 32'(grant_seq()), 32'h12);
    chk("t2_gap_before_m1", 32'(ak_b - ak_a), 32'd5);

    // 3: m0 back-to-back reads against a pending m1
    repeat (4) tick();
    grant_log.delete(); grant_cyc.delete();
    fork
      begin
        xfer(0, 1'b0, 32'h2000, 32'h0, rd_a, rq_a, ak_a);
        xfer(0, 1'b0, 32'h2000, 32'h0, rd_c, rq_c, ak_c);
      end
      xfer(1, 1'b0, 32'h14, 32'h0, rd_b, rq_b, ak_b);
    join
    repeat (3) tick();
    chk("t3_grant_seq", 32'(grant_seq()), 32'h121);
    chk("t3_m1_rdata", rd_b, 32'h0000_1111);

    // 4: m1 abort in BUSY cycle 2, stale ack in GAP, then a clean m0 transfer
    repeat (4) tick();
    ack_cnt0 = 0; ack_cnt1 = 0;
    drive(1, 1'b1, 1'b1, 32'h18, 32'h0000_3333);
    tick();
    tick();
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    force_ack = 1;
    tick();
    force_ack = 0;
    repeat (4) tick();
    chk("t4_no_m1_ack", 32'(ack_cnt1), 32'd0);
    chk("t4_no_m0_ack", 32'(ack_cnt0), 32'd0);
    xfer(0, 1'b0, 32'h18, 32'h0, rd_a, rq_a, ak_a);
    repeat (3) tick();
    chk("t4_m0_one_ack", 32'(ack_cnt0), 32'd1);
    chk("t4_reg_untouched", rd_a, 32'h0000_2222);

    // 5: slave ack stuck low
    stuck = 1;
    ack_cnt0 = 0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    rq_a = cycle;
    ak_a = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m0_ack && ak_a < 0) begin
        ak_a = cycle;
        rd_a = m0_rd;
      end
    end
`ifdef TIMER_ARB_TIMEOUT_EN
    chk("t5_timeout_latency", 32'(ak_a - rq_a), 32'd16);
    chk("t5_timeout_data", rd_a, 32'hDEAD_BEEF);
    chk("t5_timeout_flag", 32'(timeout_o), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    stuck = 0;
    repeat (4) tick();
    xfer(1, 1'b0, 32'h10, 32'h0, rd_b, rq_b, ak_b);
    chk("t5_after_rdata", rd_b, 32'h0000_0400);
    chk("t5_flag_sticky", 32'(timeout_o), 32'd1);
`else
    chk("t5_no_ack", 32'(ack_cnt0), 32'd0);
    chk("t5_still_busy", 32'(grant_o), 32'd1);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    stuck = 0;
    repeat (4) tick();
    chk("t5_no_flag", 32'(timeout_o), 32'd0);
    chk("t5_idle_after_abort", 32'(grant_o), 32'd0);
`endif

    // 6: asynchronous reset in the middle of BUSY
    repeat (2) tick();
    drive(0, 1'b1, 1'b1, 32'h1C, 32'h0000_5555);
    tick();
    tick();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t6_async_grant", 32'(grant_o), 32'd0);
    chk("t6_async_bus", {28'h0, s_cyc_o, s_stb_o, m0_ack, timeout_o}, 32'd0);
    chk("t6_async_addr", s_addr_o, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    xfer(0, 1'b0, 32'h1C, 32'h0, rd_a, rq_a, ak_a);
    chk("t6_post_latency", 32'(ak_a - rq_a), 32'd3);
    chk("t6_write_dropped", rd_a, 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
